// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between mult_seq_ctrl, the operand source/consumer and the
// shift-and-add datapath. The master side is the controller.
interface mult_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             inputdata_ready;
  logic             mult_lsb;
  logic             mult_zero;
  logic             result_ack;
  logic             loaddata;
  logic             clear_acc;
  logic             add_en;
  logic             shift_en;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] iter_count;

  modport master (
    input  inputdata_ready,
    input  mult_lsb,
    input  mult_zero,
    input  result_ack,
    output loaddata,
    output clear_acc,
    output add_en,
    output shift_en,
    output busy,
    output result_valid,
    output iter_count
  );

  modport slave (
    output inputdata_ready,
    output mult_lsb,
    output mult_zero,
    output result_ack,
    input  loaddata,
    input  clear_acc,
    input  add_en,
    input  shift_en,
    input  busy,
    input  result_valid,
    input  iter_count
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Four-state (IDLE/LOAD/RUN/DONE) controller for the sequential shift-and-add multiplier.
// Define MULT_EARLY_TERM_EN to end RUN as soon as the multiplier register reaches zero.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             run_zero;

  logic loaddata, clear_acc, add_en, shift_en, busy, result_valid;

`ifdef MULT_EARLY_TERM_EN
  assign run_zero = bus.mult_zero;
`else
  logic unused_mult_zero;
  assign unused_mult_zero = bus.mult_zero;
  assign run_zero         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    loaddata     = 1'b0;
    clear_acc    = 1'b0;
    add_en       = 1'b0;
    shift_en     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.inputdata_ready) state_d = StLoad;
      end
      StLoad: begin
        loaddata  = 1'b1;
        clear_acc = 1'b1;
        busy      = 1'b1;
        iter_d    = '0;
        state_d   = StRun;
      end
      StRun: begin
        busy = 1'b1;
        // A zero multiplier has nothing left to add; finish without touching the datapath.
        if (run_zero) begin
          state_d = StDone;
        end else begin
          shift_en = 1'b1;
          add_en   = bus.mult_lsb;
          iter_d   = iter_q + CNT_W'(1);
          if (iter_q == LastIter) state_d = StDone;
        end
      end
      StDone: begin
        result_valid = 1'b1;
        if (bus.result_ack) state_d = bus.inputdata_ready ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.loaddata     = loaddata;
  assign bus.clear_acc    = clear_acc;
  assign bus.add_en       = add_en;
  assign bus.shift_en     = shift_en;
  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed/randomized bench for mult_seq_ctrl: a behavioural datapath closes the loop and the
// expected RUN length comes from the multiplier value (MULT_EARLY_TERM_EN aware).
module tb_mult_seq_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Main DUT, WIDTH=8
  logic         ready, ack;
  logic [W-1:0] op_a, op_b;
  mult_seq_ctrl_if #(.WIDTH(W)) bif ();
  mult_seq_ctrl #(.WIDTH(W)) u_dut (.clk(clk), .reset(reset), .bus(bif));

  logic [W-1:0]   mreg;
  logic [2*W-1:0] mcand, acc;
  assign bif.inputdata_ready = ready;
  assign bif.result_ack      = ack;
  assign bif.mult_lsb        = mreg[0];
  assign bif.mult_zero       = (mreg == '0);

  always_ff @(posedge clk) begin
    if (bif.loaddata) begin
      mreg  <= op_b;
      mcand <= {{W{1'b0}}, op_a};
    end else if (bif.shift_en) begin
      mreg  <= mreg >> 1;
      mcand <= mcand << 1;
    end
    if (bif.clear_acc)   acc <= '0;
    else if (bif.add_en) acc <= acc + mcand;
  end

  // Width-corner DUTs (WIDTH=2 and WIDTH=32) sharing one stimulus
  logic        x_ready, x_ack;
  logic [31:0] x_op;
  mult_seq_ctrl_if #(.WIDTH(2))  if2 ();
  mult_seq_ctrl_if #(.WIDTH(32)) if32 ();
  mult_seq_ctrl #(.WIDTH(2))  u_w2  (.clk(clk), .reset(reset), .bus(if2));
  mult_seq_ctrl #(.WIDTH(32)) u_w32 (.clk(clk), .reset(reset), .bus(if32));

  logic [1:0]  mreg2;
  logic [31:0] mreg32;
  int          sh2, sh32;
  assign if2.inputdata_ready  = x_ready;
  assign if32.inputdata_ready = x_ready;
  assign if2.result_ack       = x_ack;
  assign if32.result_ack      = x_ack;
  assign if2.mult_lsb         = mreg2[0];
  assign if2.mult_zero        = (mreg2 == '0);
  assign if32.mult_lsb        = mreg32[0];
  assign if32.mult_zero       = (mreg32 == '0);

  always_ff @(posedge clk) begin
    if (if2.loaddata) begin
      mreg2 <= x_op[1:0];
      sh2   <= 0;
    end else if (if2.shift_en) begin
      mreg2 <= mreg2 >> 1;
      sh2   <= sh2 + 1;
    end
    if (if32.loaddata) begin
      mreg32 <= x_op;
      sh32   <= 0;
    end else if (if32.shift_en) begin
      mreg32 <= mreg32 >> 1;
      sh32   <= sh32 + 1;
    end
  end

  // Number of shifting RUN cycles for multiplier m on a w-bit controller.
  function automatic int nshift(input int w, input logic [31:0] m);
    int n;
    n = w;
`ifdef MULT_EARLY_TERM_EN
    n = 0;
    for (int i = 0; i < w; i++) if (m[i]) n = i + 1;
`endif
    if (m === 32'hx) n = -1;
    return n;
  endfunction

  // Total RUN cycles: shifting cycles plus one zero-detect cycle when terminated early.
  function automatic int nruns(input int w, input int ns);
    return (ns == w) ? w : ns + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int iter);
    check({tag, "_loaddata"}, 64'(bif.loaddata), 64'd0);
    check({tag, "_clear"}, 64'(bif.clear_acc), 64'd0);
    check({tag, "_add"}, 64'(bif.add_en), 64'd0);
    check({tag, "_shift"}, 64'(bif.shift_en), 64'd0);
    check({tag, "_busy"}, 64'(bif.busy), 64'd0);
    check({tag, "_valid"}, 64'(bif.result_valid), 64'd0);
    check({tag, "_iter"}, 64'(bif.iter_count), 64'(iter));
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a  = a;
    op_b  = b;
    ready = 1'b1;
  endtask

  // Expects the operation to enter LOAD on the next edge. Leaves ack raised on exit.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ack_wait,
                       input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
    int ns, runs;
    ns   = nshift(W, 32'(b));
    runs = nruns(W, ns);
    tick();
    ack = 1'b0;
    check("load_loaddata", 64'(bif.loaddata), 64'd1);
    check("load_clear", 64'(bif.clear_acc), 64'd1);
    check("load_busy", 64'(bif.busy), 64'd1);
    check("load_shift", 64'(bif.shift_en), 64'd0);
    check("load_valid", 64'(bif.result_valid), 64'd0);
    for (int k = 0; k < runs; k++) begin
      tick();
      ready = 1'($urandom);
      ack   = 1'($urandom);
      check("run_shift", 64'(bif.shift_en), 64'(k < ns));
      check("run_add", 64'(bif.add_en), (k < ns) ? 64'(b[k]) : 64'd0);
      check("run_iter", 64'(bif.iter_count), 64'(k));
      check("run_busy", 64'(bif.busy), 64'd1);
      check("run_valid", 64'(bif.result_valid), 64'd0);
      check("run_loaddata", 64'(bif.loaddata), 64'd0);
    end
    tick();
    ack   = 1'b0;
    ready = 1'($urandom);
    check("done_product", 64'(acc), 64'(a) * 64'(b));
    for (int d = 0; d <= ack_wait; d++) begin
      if (d > 0) tick();
      check("done_valid", 64'(bif.result_valid), 64'd1);
      check("done_iter", 64'(bif.iter_count), 64'(ns));
      check("done_busy", 64'(bif.busy), 64'd0);
      check("done_shift", 64'(bif.shift_en), 64'd0);
      check("done_add", 64'(bif.add_en), 64'd0);
      check("done_loaddata", 64'(bif.loaddata), 64'd0);
    end
    ack   = 1'b1;
    ready = chain;
    if (chain) begin
      op_a = na;
      op_b = nb;
    end
  endtask

  task automatic end_idle(input logic [W-1:0] b);
    tick();
    ack   = 1'b0;
    ready = 1'b0;
    check_idle("after_ack", nshift(W, 32'(b)));
    tick();
    check_idle("idle_hold", nshift(W, 32'(b)));
  endtask

  initial begin
    logic [W-1:0] ca, cb, na, nb;
    bit           chain;
    bit           done;
    reset   = 1'b1;
    ready   = 1'b0;
    ack     = 1'b0;
    op_a    = '0;
    op_b    = '0;
    x_ready = 1'b0;
    x_ack   = 1'b0;
    x_op    = '0;
    #1;
    check_idle("reset", 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();
    check_idle("post_reset", 0);

    // 0xA5 with a 5-cycle ack delay
    ca = W'($urandom);
    start(ca, 8'hA5);
    do_op(ca, 8'hA5, 5, 1'b0, '0, '0);
    end_idle(8'hA5);

    // Ack and next ready together: straight back into LOAD
    start(8'd13, 8'h5A);
    do_op(8'd13, 8'h5A, 0, 1'b1, 8'd200, 8'hFF);
    do_op(8'd200, 8'hFF, 1, 1'b0, '0, '0);
    end_idle(8'hFF);

    // Small multipliers (early termination candidates)
    start(8'd77, 8'h03);
    do_op(8'd77, 8'h03, 0, 1'b0, '0, '0);
    end_idle(8'h03);
    start(8'd91, 8'h00);
    do_op(8'd91, 8'h00, 2, 1'b0, '0, '0);
    end_idle(8'h00);

    // Random chained/unchained operations
    ca = W'($urandom);
    cb = W'($urandom);
    start(ca, cb);
    for (int i = 0; i < 12; i++) begin
      na    = W'($urandom);
      nb    = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      chain = (i != 11) && 1'($urandom);
      do_op(ca, cb, $urandom_range(0, 3), chain, na, nb);
      if (!chain) begin
        end_idle(cb);
        if (i != 11) start(na, nb);
      end
      ca = na;
      cb = nb;
    end

    // Asynchronous reset in the middle of RUN
    start(8'd255, 8'hFF);
    tick();
    ready = 1'b0;
    repeat (4) tick();
    check("midrun_iter", 64'(bif.iter_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    check_idle("async_reset", 0);
    tick();
    check_idle("reset_held", 0);
    #3 reset = 1'b0;
    tick();
    check_idle("reset_release", 0);
    start(8'd255, 8'hFF);
    do_op(8'd255, 8'hFF, 0, 1'b0, '0, '0);
    end_idle(8'hFF);

    // WIDTH=2 and WIDTH=32 corners with all-ones and zero multipliers
    for (int t = 0; t < 2; t++) begin
      x_op    = (t == 0) ? 32'hFFFF_FFFF : 32'h0;
      x_ready = 1'b1;
      tick();
      x_ready = 1'b0;
      done    = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        tick();
        done = if2.result_valid && if32.result_valid;
      end
      check("width_timeout", 64'(done), 64'd1);
      check("w2_shifts", 64'(sh2), 64'(nshift(2, x_op & 32'h3)));
      check("w2_iter", 64'(if2.iter_count), 64'(nshift(2, x_op & 32'h3)));
      check("w32_shifts", 64'(sh32), 64'(nshift(32, x_op)));
      check("w32_iter", 64'(if32.iter_count), 64'(nshift(32, x_op)));
      x_ack = 1'b1;
      tick();
      x_ack = 1'b0;
      check("w2_idle", 64'({if2.busy, if2.result_valid}), 64'd0);
      check("w32_idle", 64'({if32.busy, if32.result_valid}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Parametrised control unit for the team's sequential shift-and-add multiplier. It generalises the earlier two-state load/multiply controller into a four-state machine with:
- an iteration counter sized by operand width;
- a per-bit add/shift sequence;
- a held result-valid/acknowledge handshake toward the consumer.

It sits between the operand source and the multiplier datapath: it drives the datapath strobes and reads back two status bits.

## Interface
- WIDTH, 8, operand width in bits and the number of RUN iterations; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), localparam, width of the iteration counter.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- inputdata_ready  in  1  source has valid operands and holds them until loaddata is seen.
- mult_lsb  in  1  current LSB of the datapath multiplier register.
- mult_zero  in  1  datapath multiplier register is all zeros; used only with MULT_EARLY_TERM_EN.
- result_ack  in  1  consumer accepts the product.
- loaddata  out  1  load operands into the datapath; also the accept strobe to the source.
- clear_acc  out  1  clear the accumulator.
- add_en  out  1  add the multiplicand into the accumulator this cycle.
- shift_en  out  1  shift the multiplicand left by 1 and the multiplier right by 1 this cycle.
- busy  out  1  operation in progress (LOAD or RUN).
- result_valid  out  1  accumulator holds the final product.
- iter_count  out  CNT_W  completed RUN iterations.

## Operation
- States are IDLE, LOAD, RUN and DONE, held in a registered state. Outputs are decoded from state; add_en additionally uses mult_lsb.
- IDLE: all strobes are 0. If inputdata_ready=1, go to LOAD.
- LOAD, one cycle:
  - loaddata=1, clear_acc=1, busy=1.
  - iter_count is cleared to 0.
  - Go to RUN.
- RUN: shift_en=1, add_en=mult_lsb, busy=1, iter_count increments.
  - When iter_count==WIDTH-1 in the current cycle, go to DONE. Exactly WIDTH RUN cycles occur.
- DONE: result_valid=1, held until result_ack=1.
  - On ack with inputdata_ready=1, go directly to LOAD (back-to-back operation).
  - On ack with inputdata_ready=0, go to IDLE.
- inputdata_ready is ignored in LOAD, RUN and DONE-without-ack. Operands are never lost: the source holds them until loaddata.
- result_ack is ignored outside DONE.
- iter_count holds its value in DONE and IDLE. It is cleared only in LOAD.
- Datapath convention: the multiplicand shifts left, the multiplier shifts right, and the accumulator is 2*WIDTH bits and does not shift.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, iter_count=0, and all outputs are 0 in the same instant. The first possible LOAD is the cycle after the first clock edge with reset=0 and inputdata_ready=1.
- Latency, with inputdata_ready sampled high in IDLE at edge 0:
  - LOAD occupies cycle 1.
  - RUN occupies cycles 2..WIDTH+1.
  - result_valid=1 from cycle WIDTH+2.
  - WIDTH=8 gives result_valid at cycle 10.
- Back-to-back throughput is WIDTH+2 cycles per product, with zero idle cycles when the ack and the next ready coincide.
- iter_count wraps never; its maximum value is WIDTH, which CNT_W accommodates.
- All outputs are glitch-free registered-state decodes, except add_en, which follows mult_lsb combinationally in RUN.

## Configuration
- MULT_EARLY_TERM_EN, when defined: in RUN, if mult_zero=1 then add_en=0, shift_en=0, iter_count is not incremented, and the next state is DONE. This saves the cycles spent on leading zeros.
- MULT_EARLY_TERM_EN, when undefined: mult_zero is ignored and RUN always lasts exactly WIDTH cycles.

## Test plan
- Reset mid-RUN (WIDTH=8, reset raised at RUN iteration 3) -> all outputs 0 and iter_count=0 immediately; IDLE after release; a new operation completes normally.
- WIDTH=8, multiplier 0xA5, inputdata_ready pulse:
  - loaddata and clear_acc are 1 for exactly cycle 1;
  - shift_en=1 for cycles 2-9;
  - add_en pattern 1,0,1,0,0,1,0,1;
  - result_valid at cycle 10.
- result_ack withheld 5 cycles in DONE -> result_valid held for 5 cycles; no strobes; iter_count stays 8; IDLE after ack.
- result_ack and inputdata_ready both high in DONE -> next cycle LOAD (loaddata=1), no IDLE cycle; second product valid 10 cycles later.
- Early termination:
  - MULT_EARLY_TERM_EN defined, multiplier 0x03 -> 2 RUN cycles with shift_en, then one RUN cycle seeing mult_zero=1 with no strobes; result_valid at cycle 5.
  - Undefined, same stimulus -> result_valid at cycle 10.
- WIDTH=2 and WIDTH=32 builds, with multipliers all-ones and zero -> RUN length of 2 and 32 respectively; iter_count reaches 2 and 32 without overflow.
